cp0_exc_unit: RTL and testbench

//  Coprocessor-0 exception/interrupt unit. Consumes the timer IRQs and the external interrupt line
//  as HWInt[5:0], plus the exception code the pipeline carries into the M stage.

---
 rtl/cp0_pkg.sv | 57 +++++
 rtl/cp0_int_arb.sv | 21 ++
 rtl/cp0_exc_unit.sv | 94 +++++++++
 tb/tb_cp0_exc_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, exception codes and field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int SR_IM_HI    = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_BD    = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  // Unimplemented bits of both registers read as zero.
  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_HI:SR_IM_LO] = s.im;
    w[SR_EXL] = s.exl;
    w[SR_IE] = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD] = c.bd;
    w[CAUSE_IP_HI:CAUSE_IP_LO] = c.ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO] = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_int_arb.sv
// rtl/cp0_int_arb.sv - Interrupt/exception arbitration; interrupts win over exceptions.
module cp0_int_arb
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_in,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] exc_code_next
);

  assign int_req       = ie & ~exl & (|(im & hw_int));
  assign exc_req       = (exc_code_in != EXC_INT) & ~exl;
  assign req           = int_req | exc_req;
  assign exc_code_next = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 SR/Cause/EPC/PRId registers and exception request.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2024_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_din,
  output logic [31:0] cp0_dout,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  sr_t         sr;
  cause_t      cause;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [4:0]  exc_code_next;
  logic [31:0] victim_pc;
  logic [31:0] epc_next;
  logic        unused_vpc_lo;

  cp0_int_arb u_arb (
    .ie            (sr.ie),
    .exl           (sr.exl),
    .im            (sr.im),
    .hw_int        (hw_int),
    .exc_code_in   (exc_code_in),
    .int_req       (int_req),
    .exc_req       (exc_req),
    .req           (req),
    .exc_code_next (exc_code_next)
  );

  // A delay-slot victim restarts at its branch, one word earlier; wraps below zero.
  assign victim_pc     = {vpc[31:2], 2'b00};
  assign epc_next      = bd_in ? victim_pc - 32'd4 : victim_pc;
  assign unused_vpc_lo = ^{vpc[1:0], exc_req};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      cause.ip <= hw_int;
      if (req) begin
        sr.exl         <= 1'b1;
        cause.exc_code <= exc_code_next;
        cause.bd       <= bd_in;
        epc            <= epc_next;
      end else if (exl_clr) begin
        sr.exl <= 1'b0;
      end else if (we) begin
        case (cp0_addr)
          CP0_SR: begin
            sr.im  <= cp0_din[SR_IM_HI:SR_IM_LO];
            sr.exl <= cp0_din[SR_EXL];
            sr.ie  <= cp0_din[SR_IE];
          end
          CP0_EPC: epc <= {cp0_din[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cp0_dout = '0;
    case (cp0_addr)
      CP0_SR:    cp0_dout = pack_sr(sr);
      CP0_CAUSE: cp0_dout = pack_cause(cause);
      CP0_EPC:   cp0_dout = epc;
      CP0_PRID:  cp0_dout = PRID_VAL;
      default:   cp0_dout = '0;
    endcase
  end

  assign epc_out    = epc;
  assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - Vector table, directed reset sequence and randomized model check for cp0_exc_unit.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h2024_0007;
  localparam logic [31:0] HPC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din;
  logic [31:0] cp0_dout;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  int tests = 0;
  int fails = 0;

  cp0_exc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .cp0_addr    (cp0_addr),
    .cp0_din     (cp0_din),
    .cp0_dout    (cp0_dout),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .epc_out     (epc_out),
    .handler_pc  (handler_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epc;
  } vec_t;

  // Architectural model: registers held as their 32-bit read images.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && (((m_sr >> 10) & {26'h0, hw_int}) != 0);
  endfunction

  function automatic logic m_take();
    return m_int() || (exc_code_in != 0 && !m_sr[1]);
  endfunction

  task automatic model_update();
    logic take, irq;
    take = m_take();
    irq  = m_int();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw_int) << 10);
      if (take) begin
        m_sr    = m_sr | 32'h2;
        m_cause = (32'(bd_in) << 31) | (32'(hw_int) << 10) | (32'(irq ? 5'd0 : exc_code_in) << 2);
        m_epc   = (vpc & ~32'h3) - (bd_in ? 32'd4 : 32'd0);
      end else if (exl_clr) begin
        m_sr = m_sr & ~32'h2;
      end else if (we) begin
        if (cp0_addr == 5'd12) m_sr = cp0_din & 32'h0000_FC03;
        else if (cp0_addr == 5'd14) m_epc = cp0_din & ~32'h3;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we = v.we; cp0_addr = v.addr; cp0_din = v.din; vpc = v.vpc;
    bd_in = v.bd; exc_code_in = v.exc; hw_int = v.hw; exl_clr = v.clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] pc, input logic b, input logic [4:0] e,
                              input logic [5:0] h, input logic c, input logic rq,
                              input logic [31:0] dout, input logic [31:0] ep);
    vec_t v;
    v.we = w; v.addr = a; v.din = d; v.vpc = pc; v.bd = b; v.exc = e; v.hw = h; v.clr = c;
    v.exp_req = rq; v.exp_dout = dout; v.exp_epc = ep;
    return v;
  endfunction

  vec_t tbl[30];
  vec_t idle;
  logic [4:0] codes[8];

  initial begin
    idle = mk(0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // timer irq taken
    tbl[0]  = mk(1, 12, 32'h401, 0,       0, 0,  1, 0, 0, 32'h0,         32'h0);
    tbl[1]  = mk(0, 12, 0,       32'h3010, 0, 0,  1, 0, 1, 32'h401,       32'h0);
    tbl[2]  = mk(0, 13, 0,       0,       0, 0,  1, 0, 0, 32'h400,       32'h3010);
    tbl[3]  = mk(0, 12, 0,       0,       0, 0,  0, 0, 0, 32'h403,       32'h3010);
    // delay-slot overflow
    tbl[4]  = mk(1, 12, 32'h0,   0,       0, 0,  0, 0, 0, 32'h403,       32'h3010);
    tbl[5]  = mk(0, 14, 0,       32'h3024, 1, 12, 0, 0, 1, 32'h3010,      32'h3010);
    tbl[6]  = mk(0, 13, 0,       0,       0, 0,  0, 0, 0, 32'h8000_0030, 32'h3020);
    // masking then eret
    tbl[7]  = mk(1, 12, 32'h403, 0,       0, 0,  0, 0, 0, 32'h2,         32'h3020);
    tbl[8]  = mk(0, 12, 0,       32'h3050, 0, 10, 1, 0, 0, 32'h403,       32'h3020);
    tbl[9]  = mk(0, 12, 0,       32'h3050, 0, 10, 1, 1, 0, 32'h403,       32'h3020);
    tbl[10] = mk(0, 12, 0,       32'h3030, 0, 0,  1, 0, 1, 32'h401,       32'h3020);
    tbl[11] = mk(0, 13, 0,       0,       0, 0,  0, 0, 0, 32'h400,       32'h3030);
    // collision of mtc0 EPC with AdEL
    tbl[12] = mk(1, 12, 32'h0,   0,       0, 0,  0, 0, 0, 32'h403,       32'h3030);
    tbl[13] = mk(1, 14, 32'h5557, 32'h3000, 0, 4, 0, 0, 1, 32'h3030,      32'h3030);
    tbl[14] = mk(0, 14, 0,       0,       0, 0,  0, 0, 0, 32'h3000,      32'h3000);
    tbl[15] = mk(1, 14, 32'h5557, 0,      0, 0,  0, 0, 0, 32'h3000,      32'h3000);
    tbl[16] = mk(0, 14, 0,       0,       0, 0,  0, 0, 0, 32'h5554,      32'h5554);
    // interrupt beats syscall
    tbl[17] = mk(1, 12, 32'h1001, 0,      0, 0,  0, 0, 0, 32'h2,         32'h5554);
    tbl[18] = mk(0, 13, 0,       32'h3040, 0, 8,  4, 0, 1, 32'h10,        32'h5554);
    tbl[19] = mk(0, 13, 0,       0,       0, 0,  0, 0, 0, 32'h1000,      32'h3040);
    // EPC wrap-around
    tbl[20] = mk(1, 12, 32'h0,   0,       0, 0,  0, 0, 0, 32'h1003,      32'h3040);
    tbl[21] = mk(0, 14, 0,       32'h0,   1, 5,  0, 0, 1, 32'h3040,      32'h3040);
    tbl[22] = mk(0, 14, 0,       0,       0, 0,  0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    tbl[23] = mk(0, 15, 0,       0,       0, 0,  0, 0, 0, PRID,          32'hFFFF_FFFC);
    tbl[24] = mk(0, 13, 0,       0,       0, 0,  0, 0, 0, 32'h8000_0014, 32'hFFFF_FFFC);
    tbl[25] = mk(0, 3,  0,       0,       0, 0,  0, 0, 0, 32'h0,         32'hFFFF_FFFC);
    // SR write masking, Cause is read-only
    tbl[26] = mk(1, 12, 32'hFFFF_FFFF, 0, 0, 0,  0, 0, 0, 32'h2,         32'hFFFF_FFFC);
    tbl[27] = mk(0, 12, 0,       0,       0, 0,  0, 0, 0, 32'hFC03,      32'hFFFF_FFFC);
    tbl[28] = mk(1, 13, 32'hFFFF_FFFF, 0, 0, 0,  0, 0, 0, 32'h8000_0014, 32'hFFFF_FFFC);
    tbl[29] = mk(0, 13, 0,       0,       0, 0,  0, 0, 0, 32'h8000_0014, 32'hFFFF_FFFC);

    codes[0] = 0; codes[1] = 0; codes[2] = 0; codes[3] = 4;
    codes[4] = 5; codes[5] = 8; codes[6] = 10; codes[7] = 12;

    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1;
    drive(idle);
    tick();
    tick();
    reset = 1'b0;

    chk("reset_req", {31'h0, req}, 32'h0);
    chk("reset_epc_out", epc_out, 32'h0);
    chk("handler_pc", handler_pc, HPC);
    for (int a = 12; a <= 15; a++) begin
      cp0_addr = 5'(a);
      #1;
      chk($sformatf("reset_read_%0d", a), cp0_dout, (a == 15) ? PRID : 32'h0);
    end

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_req", i), {31'h0, req}, {31'h0, tbl[i].exp_req});
      chk($sformatf("vec%0d_dout", i), cp0_dout, tbl[i].exp_dout);
      chk($sformatf("vec%0d_epc", i), epc_out, tbl[i].exp_epc);
      tick();
    end

    // reset mid-operation with EXL=1 and EPC=0x3040
    drive(mk(1, 14, 32'h3040, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    drive(idle);
    #1;
    chk("pre_reset_epc", epc_out, 32'h3040);
    cp0_addr = 12;
    #1;
    chk("pre_reset_exl", cp0_dout & 32'h2, 32'h2);
    reset = 1'b1;
    hw_int = 6'd1; exc_code_in = 5'd4;
    tick();
    reset = 1'b0;
    drive(idle);
    #1;
    chk("post_reset_req", {31'h0, req}, 32'h0);
    chk("post_reset_epc", epc_out, 32'h0);
    for (int a = 12; a <= 15; a++) begin
      cp0_addr = 5'(a);
      #1;
      chk($sformatf("post_reset_read_%0d", a), cp0_dout, (a == 15) ? PRID : 32'h0);
    end

    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      we          = ($urandom_range(0, 2) == 0);
      cp0_addr    = 5'(10 + $urandom_range(0, 6));
      cp0_din     = $urandom;
      vpc         = $urandom;
      bd_in       = 1'($urandom_range(0, 1));
      exc_code_in = codes[$urandom_range(0, 7)];
      hw_int      = 6'($urandom_range(0, 7));
      exl_clr     = ($urandom_range(0, 5) == 0);
      #1;
      chk($sformatf("rnd%0d_req", n), {31'h0, req}, {31'h0, m_take()});
      chk($sformatf("rnd%0d_dout", n), cp0_dout, m_read(cp0_addr));
      chk($sformatf("rnd%0d_epc", n), epc_out, m_epc);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
